// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encodings, parity mode constants and legal parameter limits
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD = 2;
    localparam int CPB_MIN = 4;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, per-bit counter and 3-sample majority vote
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Rx_Serial,
    input  logic clr,
    output logic rx,
    output logic vote,
    output logic sample_done,
    output logic bit_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic s_a, s_b, held, maj;
    assign rx = sync[1];
    assign sample_done = cnt == CW'(MID + 1);
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign maj = (s_a & s_b) | (s_a & rx) | (s_b & rx);
    // the vote is live on the third sample and held for the rest of the bit
    assign vote = sample_done ? maj : held;
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync <= 2'b11;
            cnt <= '0;
            s_a <= 1'b1;
            s_b <= 1'b1;
            held <= 1'b1;
        end else begin
            sync <= {sync[0], i_Rx_Serial};
            cnt <= (clr || bit_end) ? '0 : cnt + CW'(1);
            if (cnt == CW'(MID - 1)) s_a <= rx;
            if (cnt == CW'(MID)) s_b <= rx;
            if (sample_done) held <= maj;
        end
    end
endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: configurable UART receiver with error/break detection and a one-entry valid/ready output
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_Valid,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Break
);
    if (CLKS_PER_BIT < CPB_MIN || DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_params
        $error("uart_rx_framed: illegal parameter combination");
    end
    state_t state, state_nx;
    logic rx, vote, sample_done, bit_end, clr;
    logic [3:0] idx;
    logic sidx, pbit, perr, ferr, done, brk_det, is_break, load;
    logic [DATA_BITS-1:0] shreg;
    uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
        .i_Clock(i_Clock),
        .i_Reset_n(i_Reset_n),
        .i_Rx_Serial(i_Rx_Serial),
        .clr(clr),
        .rx(rx),
        .vote(vote),
        .sample_done(sample_done),
        .bit_end(bit_end)
    );
    assign is_break = ~|shreg && (PARITY_MODE == PARITY_NONE || !pbit) && !vote;
    assign load = done && (!o_Rx_Valid || i_Rx_Ready);
    always_comb begin
        state_nx = state;
        done = 1'b0;
        brk_det = 1'b0;
        case (state)
            S_IDLE: state_nx = rx ? S_IDLE : S_START;
            S_START: state_nx = (sample_done && vote) ? S_IDLE : bit_end ? S_DATA : S_START;
            S_DATA: if (bit_end && idx == 4'(DATA_BITS - 1))
                state_nx = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: state_nx = bit_end ? S_STOP : S_PARITY;
            S_STOP: if (sample_done && sidx == 1'(STOP_BITS - 1)) begin
                brk_det = is_break;
                done = !is_break;
                state_nx = is_break ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: state_nx = rx ? S_IDLE : S_WAIT_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // bit timing restarts whenever the receiver goes back to waiting for a start edge
        clr = state_nx == S_IDLE || state_nx == S_WAIT_IDLE;
    end
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= S_IDLE;
            idx <= '0;
            sidx <= 1'b0;
            pbit <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE) begin
                idx <= '0;
                sidx <= 1'b0;
                pbit <= 1'b0;
                perr <= 1'b0;
                ferr <= 1'b0;
            end
            if (state == S_DATA && bit_end) begin
                shreg <= {vote, shreg[DATA_BITS-1:1]};
                idx <= idx + 4'd1;
            end
            if (state == S_PARITY && sample_done) begin
                pbit <= vote;
                perr <= vote != (^shreg ^ (PARITY_MODE == PARITY_ODD));
            end
            if (state == S_STOP && sample_done && !vote) ferr <= 1'b1;
            if (state == S_STOP && bit_end) sidx <= 1'b1;
        end
    end
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Rx_Valid <= 1'b0;
            o_Rx_Data <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Overrun <= 1'b0;
            o_Break <= 1'b0;
        end else begin
            o_Rx_Valid <= load || (o_Rx_Valid && !i_Rx_Ready);
            if (load) begin
                o_Rx_Data <= shreg;
                o_Parity_Err <= perr;
                o_Frame_Err <= ferr || !vote;
            end
            o_Overrun <= (done && !load) ? 1'b1 : (o_Rx_Valid && i_Rx_Ready) ? 1'b0 : o_Overrun;
            o_Break <= brk_det;
        end
    end
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: scoreboard bench for an 8E1 and an 8N2 receiver driven by a frame-level line model
module tb_uart_rx_framed;
    import uart_pkg::*;
    localparam int CPB = 16;
    localparam int MID = (CPB - 1) / 2;
    typedef struct packed {
        logic [7:0] d;
        logic pe;
        logic fe;
    } word_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] ser = 2'b11;
    logic [1:0] rdy = 2'b11;
    logic [1:0] valid, perr, ferr, ovr, brk;
    logic [7:0] data0, data1;
    word_t expq0[$];
    word_t expq1[$];
    int nvec = 0, errs = 0, nbrk = 0, nbrk_exp = 0;
    logic [7:0] rd;
    bit rp, rs;
    int rg;
    always #5 clk = ~clk;

    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1)) dut0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(ser[0]), .i_Rx_Ready(rdy[0]),
        .o_Rx_Valid(valid[0]), .o_Rx_Data(data0), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]),
        .o_Overrun(ovr[0]), .o_Break(brk[0])
    );
    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE), .STOP_BITS(2)) dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(ser[1]), .i_Rx_Ready(rdy[1]),
        .o_Rx_Valid(valid[1]), .o_Rx_Data(data1), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]),
        .o_Overrun(ovr[1]), .o_Break(brk[1])
    );

    function automatic void cmp(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // frame-level model: builds the wire bits, predicts word/break, then drives the line
    task automatic send(input int k, input logic [7:0] d, input logic pbad, input logic sbad,
                        input int gbit, input int idle, input bit keep);
        logic b[$];
        int nstop;
        nstop = (k == 0) ? 1 : 2;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (k == 0) b.push_back(^d ^ pbad);
        for (int s = 0; s < nstop; s++) b.push_back(!(sbad && s == nstop - 1));
        if (d == 8'h00 && sbad && (k == 1 || !pbad)) nbrk_exp++;
        else if (keep && k == 0) expq0.push_back({d, pbad, sbad});
        else if (keep) expq1.push_back({d, 1'b0, sbad});
        for (int i = 0; i < b.size(); i++)
            for (int c = 0; c < CPB; c++) begin
                tick;
                ser[k] = b[i] ^ (i == gbit && c == MID);
            end
        tick;
        ser[k] = 1'b1;
        repeat (idle) tick;
    endtask

    always @(negedge clk) begin
        if (valid[0] && rdy[0]) begin
            if (expq0.size() == 0) begin
                nvec++;
                errs++;
                $display("FAIL word0: got unexpected 0x%0h, expected no word", data0);
            end else cmp("word0", int'({data0, perr[0], ferr[0]}), int'(expq0.pop_front()));
        end
        if (valid[1] && rdy[1]) begin
            if (expq1.size() == 0) begin
                nvec++;
                errs++;
                $display("FAIL word1: got unexpected 0x%0h, expected no word", data1);
            end else cmp("word1", int'({data1, perr[1], ferr[1]}), int'(expq1.pop_front()));
        end
        if (brk[0]) nbrk++;
    end

    initial begin
        repeat (3) tick;
        cmp("reset_outputs", int'({valid, perr, ferr, ovr, brk, data0, data1}), 0);
        rst_n = 1'b1;
        repeat (4) tick;
        send(0, 8'hA5, 1'b0, 1'b0, -1, 20, 1'b1);
        send(0, 8'h01, 1'b1, 1'b0, -1, 20, 1'b1);
        send(0, 8'h3C, 1'b0, 1'b1, -1, 2 * CPB, 1'b1);
        ser[0] = 1'b0;
        repeat (3) tick;
        ser[0] = 1'b1;
        repeat (3 * CPB) tick;
        cmp("glitch_state", int'(dut0.state), int'(S_IDLE));
        cmp("glitch_valid", int'(valid[0]), 0);
        send(0, 8'h5A, 1'b0, 1'b0, 3, 20, 1'b1);
        ser[0] = 1'b0;
        nbrk_exp++;
        repeat (12 * CPB) tick;
        ser[0] = 1'b1;
        repeat (2 * CPB) tick;
        cmp("break_count", nbrk, nbrk_exp);
        cmp("break_no_word", int'(valid[0]), 0);
        send(0, 8'h7E, 1'b0, 1'b0, -1, 20, 1'b1);
        send(0, 8'h00, 1'b0, 1'b1, -1, 2 * CPB, 1'b1);
        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom);
            rp = ($urandom % 4) == 0;
            rs = ($urandom % 4) == 0;
            rg = ($urandom % 2) ? int'($urandom % 11) : -1;
            send(0, rd, rp, rs, rg, rs ? 2 * CPB : int'($urandom % 6), 1'b1);
        end
        repeat (CPB) tick;
        cmp("break_total", nbrk, nbrk_exp);
        rdy[0] = 1'b0;
        send(0, 8'h11, 1'b0, 1'b0, -1, 0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b0, -1, 20, 1'b0);
        cmp("ovr_data", int'(data0), 8'h11);
        cmp("ovr_flag", int'(ovr[0]), 1);
        cmp("ovr_valid", int'(valid[0]), 1);
        rdy[0] = 1'b1;
        repeat (4) tick;
        cmp("ovr_clear", int'(ovr[0]), 0);
        cmp("ovr_no_second", int'(valid[0]), 0);
        cmp("ovr_drained", expq0.size(), 0);
        rdy[0] = 1'b0;
        send(0, 8'h55, 1'b0, 1'b0, -1, 10, 1'b1);
        cmp("held_before_reset", int'({valid[0], data0}), 9'h155);
        fork
            send(1, 8'h99, 1'b0, 1'b0, -1, 10, 1'b0);
            begin
                repeat (4 * CPB + 8) @(posedge clk);
                #3 rst_n = 1'b0;
                #1 cmp("reset_async", int'({valid, perr, ferr, ovr, brk, data0, data1}), 0);
            end
        join
        expq0.delete();
        rdy[0] = 1'b1;
        tick;
        rst_n = 1'b1;
        repeat (4) tick;
        send(1, 8'hC3, 1'b0, 1'b0, -1, 20, 1'b1);
        for (int t = 0; t < 200 && (expq0.size() != 0 || expq1.size() != 0); t++) tick;
        cmp("q0_left", expq0.size(), 0);
        cmp("q1_left", expq1.size(), 0);
        cmp("break_final", nbrk, nbrk_exp);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised next-generation UART receiver. Configurable data width, parity and stop bits; 3-sample majority voting per bit; parity, framing and break detection. Results are delivered through a one-entry valid/ready holding register with overrun reporting. It sits between the serial pin and the byte-consuming logic (command decoder, loader) and replaces the fixed 8N1 receiver.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; legal minimum 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, legal values 1 or 2.

Ports:
i_Clock  input  1  system clock
i_Reset_n  input  1  asynchronous, active-low reset
i_Rx_Serial  input  1  asynchronous serial line, idle high
i_Rx_Ready  input  1  consumer can accept the held word
o_Rx_Valid  output  1  holding register contains a word
o_Rx_Data  output  DATA_BITS  received data, LSB first on the wire
o_Parity_Err  output  1  parity mismatch for the held word; valid with o_Rx_Valid
o_Frame_Err  output  1  a stop bit sampled 0 for the held word; valid with o_Rx_Valid
o_Overrun  output  1  sticky: at least one completed frame was dropped
o_Break  output  1  one-cycle pulse when a break is detected

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; state IDLE; counters 0.
  - the two synchroniser flops reset to 1.
- Input path: 2-flop synchroniser on i_Rx_Serial; all decisions use the synchronised line.
- Bit timing:
  - counter runs 0..CLKS_PER_BIT-1 within each bit; MID = (CLKS_PER_BIT-1)/2.
  - the line is sampled at counts MID-1, MID and MID+1; bit value = majority of the three samples.
  - counter width = clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - synchronised line 0 -> START, counter 0; that cycle counts as count 0.
- START:
  - at count MID+1, majority 1 -> IDLE (glitch rejected, no output); otherwise continue.
  - at count CLKS_PER_BIT-1 -> DATA, bit index 0.
- DATA:
  - at count CLKS_PER_BIT-1, shift in the voted bit at the current index.
  - after index DATA_BITS-1 -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - voted bit compared with XOR of the data bits (even) or its inverse (odd); mismatch latches the parity error.
  - at count CLKS_PER_BIT-1 -> STOP.
- STOP:
  - any stop bit voting 0 latches the frame error.
  - non-final stop bits run the full period.
  - the final stop bit completes at count MID+1 (half-bit slack for a back-to-back start) -> IDLE.
- Break:
  - condition: all data bits 0, parity bit 0 (if present) and final stop bit 0.
  - response: no word is delivered; o_Break pulses 1 cycle; -> WAIT_IDLE.
  - WAIT_IDLE -> IDLE once the synchronised line is 1.
- Completion (frame done, not a break):
  - if the holding register is empty, or being accepted this cycle (o_Rx_Valid & i_Rx_Ready): load o_Rx_Data, o_Parity_Err and o_Frame_Err; o_Rx_Valid = 1 next cycle.
  - else the new frame is dropped, the held word is unchanged, and o_Overrun is set.
- Handshake:
  - transfer occurs on o_Rx_Valid & i_Rx_Ready.
  - o_Rx_Valid clears after a transfer unless a new load occurs in the same cycle.
  - o_Overrun clears on the next transfer.
- Latency: line edge to START = 2 cycles (synchroniser). o_Rx_Valid asserts 1 cycle after the final-stop MID+1 sample.
- Parameter legality:
  - illegal values trigger an elaboration-time error (generate guard).
  - DATA_BITS = 9 with parity is legal.

Decomposition:
- Shared package/include uart_pkg:
  - state encodings;
  - PARITY_NONE, PARITY_EVEN and PARITY_ODD constants;
  - legal parameter limits.
- Sub-module uart_rx_sampler: synchroniser, bit counter, 3-sample majority vote. Outputs the voted bit plus sample_done (MID+1) and bit_end (CLKS_PER_BIT-1) strobes.
- The FSM and holding register stay in uart_rx_framed.

Test Plan:
- CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1, i_Rx_Ready=1; send 0xA5 with parity 0 -> one valid word 0xA5, Parity_Err=0, Frame_Err=0.
- Same configuration; send 0x01 with parity bit 0 -> valid word 0x01, Parity_Err=1. Then send 0x3C with stop bit 0 -> valid word 0x3C, Frame_Err=1.
- Glitches:
  - 3-cycle low pulse on an idle line -> no o_Rx_Valid, FSM back in IDLE.
  - in 0x5A, sample MID of bit 2 inverted -> 0x5A received, no errors.
- Break: line low for 12 bit periods -> o_Break pulse once, no o_Rx_Valid. Line high, then 0x7E -> 0x7E received.
- Overrun: i_Rx_Ready=0, send 0x11 then 0x22 back-to-back -> o_Rx_Data stays 0x11, o_Overrun=1. Raise i_Rx_Ready -> 0x11 transferred, o_Overrun=0, no 0x22 appears.
- Reset mid-frame: assert i_Reset_n=0 during data bit 3 -> all outputs 0 immediately. Release, then send 0xC3 with DATA_BITS=8, PARITY_MODE=0, STOP_BITS=2 -> 0xC3 received cleanly.
